// File: rtl/wf68k30l_opcode_prefetch_pkg.sv
// Shared types for the WF68K30L instruction prefetch queue: bus FSM states,
// queue word layout and pointer sizing.
package wf68k30l_opcode_prefetch_pkg;

  localparam int unsigned PfDepth = 8;
  localparam int unsigned PfPtrW  = $clog2(PfDepth);

  typedef enum logic [1:0] {
    BusIdle,
    BusReq,
    BusHold
  } bus_state_e;

  // A poisoned word came back from a bus-errored fetch.
  typedef struct packed {
    logic        poison;
    logic [15:0] data;
  } qword_t;

  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wf68k30l_opcode_prefetch_if.sv
// Control-unit handshake and instruction-bus signals of the prefetch unit.
interface wf68k30l_opcode_prefetch_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ow_req;
  logic        ew_req;
  logic        ew_long;
  logic        opd_ack;
  logic        ow_rdy;
  logic        ew_ack;
  logic        ew_rdy;
  logic [15:0] biw_0;
  logic [31:0] pc_opcode;
  logic [31:0] ext_word;
  logic        fetch_berr;
  logic        ifetch_req;
  logic [31:0] ifetch_adr;
  logic        ifetch_ack;
  logic        ifetch_err;
  logic [31:0] ifetch_data;

  modport master (
    output flush, flush_pc, ow_req, ew_req, ew_long, ifetch_ack, ifetch_err, ifetch_data,
    input  opd_ack, ow_rdy, ew_ack, ew_rdy, biw_0, pc_opcode, ext_word, fetch_berr,
           ifetch_req, ifetch_adr
  );

  modport slave (
    input  flush, flush_pc, ow_req, ew_req, ew_long, ifetch_ack, ifetch_err, ifetch_data,
    output opd_ack, ow_rdy, ew_ack, ew_rdy, biw_0, pc_opcode, ext_word, fetch_berr,
           ifetch_req, ifetch_adr
  );
endinterface

// File: rtl/wf68k30l_prefetch_fifo.sv
// Circular 16-bit word buffer with 0/1/2-word write and read per cycle and
// head / head+1 peek.
module wf68k30l_prefetch_fifo
  import wf68k30l_opcode_prefetch_pkg::*;
#(
  parameter  int unsigned Depth = PfDepth,
  localparam int unsigned PtrW  = ptr_width(Depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic [1:0]    i_wr_num,
  input  qword_t        i_wr_word0,
  input  qword_t        i_wr_word1,
  input  logic [1:0]    i_rd_num,
  output qword_t        o_head,
  output qword_t        o_head1,
  output logic [PtrW:0] o_count
);

  qword_t            r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW:0]     r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clr && i_wr_num != 2'd0) begin
      r_mem[r_wr_ptr] <= i_wr_word0;
      if (i_wr_num == 2'd2) r_mem[r_wr_ptr + PtrW'(1)] <= i_wr_word1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PtrW'(i_wr_num);
      r_rd_ptr <= r_rd_ptr + PtrW'(i_rd_num);
      r_count  <= r_count + (PtrW + 1)'(i_wr_num) - (PtrW + 1)'(i_rd_num);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_head1 = r_mem[r_rd_ptr + PtrW'(1)];
  assign o_count = r_count;

endmodule

// File: rtl/wf68k30l_opcode_prefetch.sv
// WF68K30L instruction prefetch: longword fetches into a word queue, served
// to the control unit as operation words and extension words.
module wf68k30l_opcode_prefetch
  import wf68k30l_opcode_prefetch_pkg::*;
#(
  parameter int unsigned Depth = PfDepth
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  wf68k30l_opcode_prefetch_if.slave    io_pf
);

  localparam int unsigned PtrW = ptr_width(Depth);

  bus_state_e  r_state;
  logic [31:0] r_fetch_ptr, r_ifetch_adr, r_word_pc, r_pc_opcode, r_ext_word;
  logic [15:0] r_biw_0;
  logic        r_skip_upper, r_discard, r_fetch_en, r_frozen;
  logic        r_ow_pend, r_ew_pend, r_ew_long;
  logic        r_opd_ack, r_ow_rdy, r_ew_ack, r_ew_rdy, r_fetch_berr;

  qword_t        w_head, w_head1, w_wr0, w_wr1;
  logic [PtrW:0] w_count;
  logic [1:0]    w_wr_num, w_rd_num, w_ew_need;
  logic          w_ow_pend, w_ew_pend, w_ew_long, w_ew_go, w_ew_bad, w_ow_go, w_ow_bad;
  logic          w_bus_done, w_start, w_unused_pc0;

  assign w_unused_pc0 = io_pf.flush_pc[0];

  wf68k30l_prefetch_fifo #(.Depth(Depth)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (io_pf.flush),
    .i_wr_num   (w_wr_num),
    .i_wr_word0 (w_wr0),
    .i_wr_word1 (w_wr1),
    .i_rd_num   (w_rd_num),
    .o_head     (w_head),
    .o_head1    (w_head1),
    .o_count    (w_count)
  );

  always_comb begin
    w_ow_pend  = r_ow_pend | io_pf.ow_req;
    w_ew_pend  = r_ew_pend | io_pf.ew_req;
    w_ew_long  = io_pf.ew_req ? io_pf.ew_long : r_ew_long;
    w_ew_need  = w_ew_long ? 2'd2 : 2'd1;
    // Extension words take priority; a pending OW waits behind any pending EW.
    w_ew_go    = !io_pf.flush && w_ew_pend && !r_frozen && w_count >= (PtrW + 1)'(w_ew_need);
    w_ew_bad   = w_ew_go && (w_head.poison || (w_ew_long && w_head1.poison));
    w_ow_go    = !io_pf.flush && !w_ew_pend && w_ow_pend && !r_frozen && w_count != '0;
    w_ow_bad   = w_ow_go && w_head.poison;
    w_rd_num   = 2'd0;
    if (w_ew_go && !w_ew_bad) w_rd_num = w_ew_need;
    else if (w_ow_go && !w_ow_bad) w_rd_num = 2'd1;

    w_bus_done = (r_state == BusReq) && (io_pf.ifetch_ack || io_pf.ifetch_err);
    w_start    = (r_state == BusIdle) && !io_pf.flush && r_fetch_en &&
                 w_count <= (PtrW + 1)'(Depth - 2);
    w_wr_num   = 2'd0;
    w_wr0      = '{poison: 1'b0, data: io_pf.ifetch_data[31:16]};
    w_wr1      = '{poison: 1'b0, data: io_pf.ifetch_data[15:0]};
    if (!io_pf.flush && w_bus_done && !r_discard) begin
      if (io_pf.ifetch_err) begin
        w_wr_num = 2'd2;
        w_wr0.poison = 1'b1;
        w_wr1.poison = 1'b1;
      end else if (r_skip_upper) begin
        w_wr_num = 2'd1;
        w_wr0    = w_wr1;
      end else begin
        w_wr_num = 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= BusIdle;
      r_fetch_ptr  <= '0;
      r_ifetch_adr <= '0;
      r_word_pc    <= '0;
      r_pc_opcode  <= '0;
      r_ext_word   <= '0;
      r_biw_0      <= '0;
      r_skip_upper <= 1'b0;
      r_discard    <= 1'b0;
      r_fetch_en   <= 1'b0;
      r_frozen     <= 1'b0;
      r_ow_pend    <= 1'b0;
      r_ew_pend    <= 1'b0;
      r_ew_long    <= 1'b0;
      r_opd_ack    <= 1'b0;
      r_ow_rdy     <= 1'b0;
      r_ew_ack     <= 1'b0;
      r_ew_rdy     <= 1'b0;
      r_fetch_berr <= 1'b0;
    end else begin
      r_opd_ack    <= 1'b0;
      r_ew_ack     <= 1'b0;
      r_fetch_berr <= 1'b0;
      if (io_pf.flush) begin
        // An outstanding bus cycle must still complete; its result is dropped.
        r_state      <= (r_state == BusReq && !w_bus_done) ? BusReq : BusIdle;
        r_discard    <= (r_state == BusReq && !w_bus_done);
        r_fetch_ptr  <= {io_pf.flush_pc[31:2], 2'b00};
        r_skip_upper <= io_pf.flush_pc[1];
        r_word_pc    <= {io_pf.flush_pc[31:1], 1'b0};
        r_fetch_en   <= 1'b1;
        r_frozen     <= 1'b0;
        r_ow_pend    <= 1'b0;
        r_ew_pend    <= 1'b0;
        r_ow_rdy     <= 1'b0;
        r_ew_rdy     <= 1'b0;
      end else begin
        unique case (r_state)
          BusIdle: if (w_start) begin
            r_state      <= BusReq;
            r_ifetch_adr <= r_fetch_ptr;
          end
          BusReq: if (w_bus_done) begin
            if (r_discard) begin
              r_state   <= BusIdle;
              r_discard <= 1'b0;
            end else if (io_pf.ifetch_err) begin
              r_state <= BusHold;
            end else begin
              r_state      <= BusIdle;
              r_fetch_ptr  <= r_fetch_ptr + 32'd4;
              r_skip_upper <= 1'b0;
            end
          end
          default: r_state <= BusHold;
        endcase

        if (io_pf.ow_req) r_ow_rdy <= 1'b0;
        if (io_pf.ew_req) r_ew_rdy <= 1'b0;
        r_ow_pend <= w_ow_pend;
        r_ew_pend <= w_ew_pend;
        r_ew_long <= w_ew_long;

        if (w_ew_go) begin
          r_ew_pend <= 1'b0;
          if (w_ew_bad) begin
            r_fetch_berr <= 1'b1;
            r_frozen     <= 1'b1;
          end else begin
            r_ext_word <= w_ew_long ? {w_head.data, w_head1.data} : {16'h0000, w_head.data};
            r_word_pc  <= r_word_pc + (w_ew_long ? 32'd4 : 32'd2);
            r_ew_ack   <= 1'b1;
            r_ew_rdy   <= 1'b1;
          end
        end
        if (w_ow_go) begin
          r_ow_pend <= 1'b0;
          if (w_ow_bad) begin
            r_fetch_berr <= 1'b1;
            r_frozen     <= 1'b1;
          end else begin
            r_biw_0     <= w_head.data;
            r_pc_opcode <= r_word_pc;
            r_word_pc   <= r_word_pc + 32'd2;
            r_opd_ack   <= 1'b1;
            r_ow_rdy    <= 1'b1;
          end
        end
      end
    end
  end

  assign io_pf.opd_ack    = r_opd_ack;
  assign io_pf.ow_rdy     = r_ow_rdy;
  assign io_pf.ew_ack     = r_ew_ack;
  assign io_pf.ew_rdy     = r_ew_rdy;
  assign io_pf.biw_0      = r_biw_0;
  assign io_pf.pc_opcode  = r_pc_opcode;
  assign io_pf.ext_word   = r_ext_word;
  assign io_pf.fetch_berr = r_fetch_berr;
  assign io_pf.ifetch_req = (r_state == BusReq);
  assign io_pf.ifetch_adr = (r_state == BusReq) ? r_ifetch_adr : 32'd0;

endmodule
